d_sram_like_bridge: RTL

//   Memory-side end of the data-access path. Takes the CPU data-SRAM request (en, byte-lane wen,

---
 rtl/d_sram_like_bridge.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/d_sram_like_bridge.sv
// d_sram_like_bridge: turns the CPU data-SRAM request into a one-outstanding
// sram-like bus transaction, returns the read word and produces the stall.
// Optional feature macro: DSRAM_WEN_CHECK_EN (reject illegal byte-enable patterns).
module d_sram_like_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            data_sram_en,
  input  logic [DW/8-1:0] data_sram_wen,
  input  logic [AW-1:0]   data_sram_addr,
  input  logic [DW-1:0]   data_sram_wdata,
  output logic [DW-1:0]   data_sram_rdata,
  input  logic            flush,
  input  logic            longest_stall,
  output logic            d_stall,
  output logic            wen_err,
  output logic            data_req,
  output logic            data_wr,
  output logic [1:0]      data_size,
  output logic [AW-1:0]   data_addr,
  output logic [DW-1:0]   data_wdata,
  input  logic [DW-1:0]   data_rdata,
  input  logic            data_addr_ok,
  input  logic            data_data_ok
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            wr_q, wr_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            discard_q, discard_d;
  logic            wen_err_q, wen_err_d;

  logic            accept_s;
  logic            complete_s;
  logic            drop_s;
  logic            illegal_s;
  logic [3:0]      enc_s;
  logic            addr_lo_unused_s;

  // Byte-enable pattern to {size, address offset}; loads and unknown patterns fetch a full word.
  function automatic logic [3:0] wen_encode(input logic [3:0] wen);
    case (wen)
      4'b0001: wen_encode = {2'd0, 2'd0};
      4'b0010: wen_encode = {2'd0, 2'd1};
      4'b0100: wen_encode = {2'd0, 2'd2};
      4'b1000: wen_encode = {2'd0, 2'd3};
      4'b0011: wen_encode = {2'd1, 2'd0};
      4'b1100: wen_encode = {2'd1, 2'd2};
      4'b1111: wen_encode = {2'd2, 2'd0};
      default: wen_encode = {2'd2, 2'd0};
    endcase
  endfunction

`ifdef DSRAM_WEN_CHECK_EN
  // Patterns the bus can express as a single naturally aligned access (0000 is a load).
  function automatic logic wen_legal(input logic [3:0] wen);
    case (wen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: wen_legal = 1'b1;
      default:                   wen_legal = 1'b0;
    endcase
  endfunction

  assign illegal_s = ~wen_legal(data_sram_wen);
`else
  assign illegal_s = 1'b0;
`endif

  // The bus address offset comes from the byte enables, never from the CPU address low bits.
  assign addr_lo_unused_s = ^data_sram_addr[1:0];

  assign enc_s      = wen_encode(data_sram_wen);
  assign accept_s   = data_sram_en & ~flush;
  assign drop_s     = discard_q | flush;
  assign complete_s = ((state_q == S_REQ) & data_addr_ok & data_data_ok) |
                      ((state_q == S_WAIT) & data_data_ok);

  // State and datapath registers; reset abandons any outstanding bus transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      rdata_q   <= {DW{1'b0}};
      discard_q <= 1'b0;
      wen_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      discard_q <= discard_d;
      wen_err_q <= wen_err_d;
    end
  end

  // Next-state: a flushed transaction still finishes on the bus but skips DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = illegal_s ? S_DONE : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (complete_s) begin
          state_d = drop_s ? S_IDLE : S_DONE;
        end else if (data_addr_ok) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (complete_s) begin
          state_d = drop_s ? S_IDLE : S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (longest_stall && !flush) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request field latching, discard tracking, read-word capture and wen_err pulse.
  always_comb begin
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    discard_d = 1'b0;
    wen_err_d = 1'b0;
    if ((state_q == S_IDLE) && accept_s) begin
      if (illegal_s) begin
        wen_err_d = 1'b1;
      end else begin
        wr_d    = |data_sram_wen;
        size_d  = enc_s[3:2];
        addr_d  = {data_sram_addr[AW-1:2], enc_s[1:0]};
        wdata_d = data_sram_wdata;
      end
    end else begin
      wen_err_d = 1'b0;
    end
    if (((state_q == S_REQ) || (state_q == S_WAIT)) && !complete_s) begin
      discard_d = drop_s;
    end else begin
      discard_d = 1'b0;
    end
    if (complete_s && !drop_s) begin
      rdata_d = data_rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Bus and pipeline outputs: request fields are register-held, stall follows the CPU enable.
  always_comb begin
    data_req        = (state_q == S_REQ);
    d_stall         = data_sram_en & (state_q != S_DONE);
    data_wr         = wr_q;
    data_size       = size_q;
    data_addr       = addr_q;
    data_wdata      = wdata_q;
    data_sram_rdata = rdata_q;
    wen_err         = wen_err_q;
  end

endmodule
